uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one UART transmitter (2..8).
REQ-002 Parameter INPUT_DATA_WIDTH, default 8: width of each transmitted word.
REQ-003 Parameter BUSY_TIMEOUT, default 16: max clk cycles to wait for tx_busy to rise after issue.
REQ-004 clk  input  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
REQ-006 req  input  NUM_REQ  per-requester request level; requester holds high, with req_data stable, until its grant.
REQ-007 req_data  input  NUM_REQ*INPUT_DATA_WIDTH  packed words; requester i occupies bits [i*W +: W].
REQ-008 grant  output  NUM_REQ  one-hot, one-cycle pulse: word accepted and issued to transmitter.
REQ-009 done  output  NUM_REQ  one-hot, one-cycle pulse: granted word has finished transmitting.
REQ-010 tx_enable  output  1  one-cycle start strobe to the UART transmitter.
REQ-011 tx_data  output  INPUT_DATA_WIDTH  word to transmit; driven to the UART i_data.
REQ-012 tx_busy  input  1  UART transmitter o_busy.
REQ-013 timeout  output  1  one-cycle pulse: tx_busy failed to rise within BUSY_TIMEOUT cycles.

Function
REQ-014 FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE; encoding free.
REQ-015 IDLE: if any req bit set and tx_busy==0, select winner, register req_data of winner into tx_data, record winner index, go to ISSUE; else stay.
REQ-016 Selection: round-robin; search starts at index (last_winner+1) mod NUM_REQ, ascending with wrap; first set req bit wins.
REQ-017 ISSUE (exactly one cycle): tx_enable=1, grant[winner]=1; go to WAIT_BUSY, clear timeout counter.
REQ-018 Latency: req sampled high in IDLE -> grant/tx_enable asserted exactly 1 cycle later.
REQ-019 WAIT_BUSY: tx_busy==1 -> WAIT_DONE; else increment counter; counter reaching BUSY_TIMEOUT-1 without busy -> timeout=1 for one cycle, no done pulse, go IDLE.
REQ-020 WAIT_DONE: on tx_busy==0 -> done[winner]=1 for one cycle, last_winner<=winner, go IDLE.
REQ-021 last_winner SHALL also update on timeout, so a failing requester cannot starve others.
REQ-022 tx_data SHALL hold stable from ISSUE until return to IDLE (UART requires stable i_data while busy).
REQ-023 tx_enable SHALL never assert while tx_busy==1 or outside ISSUE; at most one grant per transaction.
REQ-024 req changes in non-IDLE states SHALL be ignored; req of winner dropping after grant has no effect.
REQ-025 Simultaneous requests: exactly one winner per REQ-016; losers remain pending, no grant.
REQ-026 Back-to-back: done cycle returns to IDLE; next grant earliest 2 cycles after done.
REQ-027 Timeout counter width SHALL be $clog2(BUSY_TIMEOUT)+1 bits; no wrap before comparison.
REQ-028 grant, done, timeout SHALL each be one-hot-or-zero and mutually exclusive in any cycle.

Reset
REQ-029 While reset==0: state=IDLE, grant=0, done=0, tx_enable=0, timeout=0, tx_data=0, counter=0, last_winner=NUM_REQ-1 (so index 0 has first priority).
REQ-030 Reset asserted mid-transaction SHALL abort immediately; no done or timeout pulse for the aborted word; first grant no earlier than 1 cycle after reset release.

Verification
REQ-031 After reset, req=4'b0100, req_data[2]=8'hA5, tx_busy 0 -> grant=4'b0100 and tx_enable=1 one cycle later with tx_data=8'hA5; model busy for 88 cycles -> done=4'b0100 one cycle after busy falls.
REQ-032 req=4'b1111 held continuously, transmitter model looped -> grants in order 0001,0010,0100,1000,0001; each done precedes next grant by 2 cycles.
REQ-033 req=4'b0001, tx_busy held 0 forever -> grant at cycle 1, timeout pulse 16 cycles into WAIT_BUSY, no done; next req=4'b0011 grants 0010 first.
REQ-034 req=4'b0001 while tx_busy=1 in IDLE -> no grant until tx_busy low; grant 1 cycle after.
REQ-035 reset pulled low during WAIT_DONE -> outputs zero next cycle, no done; after release req=4'b1000 granted after req=4'b0001 only if 0001 absent (priority restarts at 0).
REQ-036 Formal/assertion checks across all runs: REQ-023 and REQ-028 hold every cycle; tx_data stable while tx_busy==1.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter-side bus of the UART transmit arbiter.
// The master modport is the environment (requesters plus UART model);
// the slave modport is the arbiter itself.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ          = 4,
  parameter int INPUT_DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]                  req;
  logic [NUM_REQ*INPUT_DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]                  grant;
  logic [NUM_REQ-1:0]                  done;
  logic                                tx_enable;
  logic [INPUT_DATA_WIDTH-1:0]         tx_data;
  logic                                tx_busy;
  logic                                timeout;

  modport master (
    output req, req_data, tx_busy,
    input  grant, done, tx_enable, tx_data, timeout
  );

  modport slave (
    input  req, req_data, tx_busy,
    output grant, done, tx_enable, tx_data, timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// One word is in flight at a time: select, strobe tx_enable, wait for the
// transmitter to go busy (bounded by BUSY_TIMEOUT), wait for it to go idle,
// then report done. A word whose transmitter never goes busy is dropped with
// a timeout pulse and still advances the round-robin pointer.
module uart_tx_arbiter #(
  parameter int NUM_REQ          = 4,
  parameter int INPUT_DATA_WIDTH = 8,
  parameter int BUSY_TIMEOUT     = 16
) (
  input  logic               clk,
  input  logic               reset,
  uart_tx_arbiter_if.slave   bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(BUSY_TIMEOUT) + 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t                       state;
  logic [IDX_W-1:0]             last_winner;
  logic [IDX_W-1:0]             winner;
  logic [CNT_W-1:0]             cnt;
  logic [NUM_REQ-1:0]           grant_q;
  logic [NUM_REQ-1:0]           done_q;
  logic                         tx_enable_q;
  logic                         timeout_q;
  logic [INPUT_DATA_WIDTH-1:0]  tx_data_q;

  logic                         found;
  logic [IDX_W-1:0]             win_idx;
  logic [IDX_W-1:0]             cand;
  int                           cand_i;
  logic [INPUT_DATA_WIDTH-1:0]  words [NUM_REQ];

  // Unpack the requester words so the winner can be picked with a plain index.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
    assign words[i] = bus.req_data[i*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH];
  end

  // Round-robin search starting just after the previous winner, with wrap.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    found   = 1'b0;
    win_idx = '0;
    cand_i  = 0;
    cand    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_i = (int'(last_winner) + i) % NUM_REQ;
      cand   = cand_i[IDX_W-1:0];
      if (!found && bus.req[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Transaction FSM with registered pulse outputs. The cycle that shows done
  // or timeout is never used for arbitration, so a fresh grant comes at the
  // earliest two cycles after the previous word's completion.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of statement order.
    if (!reset) begin
      state       <= IDLE;
      last_winner <= IDX_W'(NUM_REQ - 1);
      winner      <= '0;
      cnt         <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      tx_enable_q <= 1'b0;
      timeout_q   <= 1'b0;
      tx_data_q   <= '0;
    end else begin
      grant_q     <= '0;
      done_q      <= '0;
      tx_enable_q <= 1'b0;
      timeout_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (found && !bus.tx_busy && (done_q == '0) && !timeout_q) begin
            tx_data_q   <= words[win_idx];
            winner      <= win_idx;
            grant_q     <= ONE_HOT0 << win_idx;
            tx_enable_q <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.tx_busy) begin
            state <= WAIT_DONE;
          end else if (cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
            timeout_q   <= 1'b1;
            last_winner <= winner;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            done_q      <= ONE_HOT0 << winner;
            last_winner <= winner;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.tx_enable = tx_enable_q;
  assign bus.timeout   = timeout_q;
  assign bus.tx_data   = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed scenarios push timed expected
// grant/done/timeout events; a negedge monitor pops and compares every event
// the arbiter presents, and checks the per-cycle output invariants.
module tb_uart_tx_arbiter;

  typedef enum int {EV_GRANT, EV_DONE, EV_TIMEOUT} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [3:0] mask;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  ev_t  exp_q[$];

  logic       model_en   = 1'b1;
  logic       busy_force = 1'b0;
  logic       model_busy = 1'b0;
  int         busy_len   = 4;
  int         busy_cnt   = 0;
  logic [7:0] word_of [4] = '{8'h11, 8'h22, 8'hA5, 8'h44};

  uart_tx_arbiter_if #(.NUM_REQ(4), .INPUT_DATA_WIDTH(8)) bus ();

  uart_tx_arbiter #(.NUM_REQ(4), .INPUT_DATA_WIDTH(8), .BUSY_TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // UART transmitter model: busy for busy_len cycles after a start strobe.
  always @(posedge clk) begin
    if (bus.tx_enable && model_en) begin
      model_busy <= 1'b1;
      busy_cnt   <= busy_len - 1;
    end else if (model_busy) begin
      if (busy_cnt == 0) model_busy <= 1'b0;
      else               busy_cnt   <= busy_cnt - 1;
    end
  end
  assign bus.tx_busy = model_busy | busy_force;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic void expect_ev(ev_kind_t k, logic [3:0] m, logic [7:0] d, int c);
    ev_t e;
    e.kind = k;
    e.mask = m;
    e.data = d;
    e.cyc  = c;
    exp_q.push_back(e);
  endfunction

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_grant"},     32'(bus.grant),     32'h0);
    check({tag, "_done"},      32'(bus.done),      32'h0);
    check({tag, "_tx_enable"}, 32'(bus.tx_enable), 32'h0);
    check({tag, "_timeout"},   32'(bus.timeout),   32'h0);
    check({tag, "_tx_data"},   32'(bus.tx_data),   32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_zero_outputs("reset");
    reset = 1'b1;
  endtask

  // Monitor: event scoreboard plus per-cycle invariants.
  logic       prev_busy  = 1'b0;
  logic       prev_reset = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  always @(negedge clk) begin
    ev_t      e;
    ev_kind_t got;
    int       n_active;
    if (bus.grant != 4'b0 || bus.done != 4'b0 || bus.timeout) begin
      got = (bus.grant != 4'b0) ? EV_GRANT : (bus.done != 4'b0) ? EV_DONE : EV_TIMEOUT;
      if (exp_q.size() == 0) begin
        check("unexpected_event", 32'(got), 32'hFFFF);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", 32'(got), 32'(e.kind));
        check("event_cycle", 32'(cyc), 32'(e.cyc));
        if (e.kind == EV_GRANT) begin
          check("grant_mask", 32'(bus.grant), 32'(e.mask));
          check("grant_tx_data", 32'(bus.tx_data), 32'(e.data));
        end else if (e.kind == EV_DONE) begin
          check("done_mask", 32'(bus.done), 32'(e.mask));
        end
      end
    end
    n_active = int'(bus.grant != 4'b0) + int'(bus.done != 4'b0) + int'(bus.timeout);
    check("onehot_exclusive",
          32'($onehot0(bus.grant) && $onehot0(bus.done) && n_active <= 1), 32'h1);
    check("tx_enable_rule",
          32'((bus.tx_enable == (bus.grant != 4'b0)) && !(bus.tx_enable && bus.tx_busy)), 32'h1);
    if (reset && prev_reset && bus.tx_busy && prev_busy)
      check("tx_data_stable", 32'(bus.tx_data), 32'(prev_data));
    prev_busy  = bus.tx_busy;
    prev_reset = reset;
    prev_data  = bus.tx_data;
  end

  initial begin
    int c;
    int t;
    reset        = 1'b0;
    bus.req      = 4'b0;
    bus.req_data = {8'h44, 8'hA5, 8'h22, 8'h11};
    @(negedge clk);
    @(negedge clk);
    check_zero_outputs("por");
    reset = 1'b1;

    // Single request from index 2, long transmission.
    @(negedge clk);
    busy_len = 88;
    c = cyc;
    bus.req = 4'b0100;
    expect_ev(EV_GRANT, 4'b0100, 8'hA5, c + 1);
    expect_ev(EV_DONE,  4'b0100, 8'h00, c + 91);
    wait_until(c + 1);
    bus.req = 4'b0000;
    wait_until(c + 95);

    // All four requesting continuously: rotation 0,1,2,3,0.
    do_reset();
    busy_len = 3;
    c = cyc;
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      expect_ev(EV_GRANT, 4'(1 << (k % 4)), word_of[k % 4], c + 1 + 7*k);
      expect_ev(EV_DONE,  4'(1 << (k % 4)), 8'h00,          c + 6 + 7*k);
    end
    wait_until(c + 29);
    bus.req = 4'b0000;
    wait_until(c + 37);

    // Transmitter never goes busy: timeout, then pointer has moved past 0.
    do_reset();
    model_en = 1'b0;
    c = cyc;
    bus.req = 4'b0001;
    expect_ev(EV_GRANT,   4'b0001, 8'h11, c + 1);
    expect_ev(EV_TIMEOUT, 4'b0000, 8'h00, c + 18);
    wait_until(c + 1);
    bus.req = 4'b0000;
    wait_until(c + 19);
    model_en = 1'b1;
    busy_len = 2;
    t = cyc;
    bus.req = 4'b0011;
    expect_ev(EV_GRANT, 4'b0010, 8'h22, t + 1);
    expect_ev(EV_DONE,  4'b0010, 8'h00, t + 5);
    expect_ev(EV_GRANT, 4'b0001, 8'h11, t + 7);
    expect_ev(EV_DONE,  4'b0001, 8'h00, t + 11);
    wait_until(t + 1);
    bus.req = 4'b0001;
    wait_until(t + 7);
    bus.req = 4'b0000;
    wait_until(t + 14);

    // Request held off while the transmitter is already busy.
    c = cyc;
    busy_force = 1'b1;
    bus.req = 4'b0001;
    wait_until(c + 5);
    busy_force = 1'b0;
    expect_ev(EV_GRANT, 4'b0001, 8'h11, c + 6);
    expect_ev(EV_DONE,  4'b0001, 8'h00, c + 10);
    wait_until(c + 6);
    bus.req = 4'b0000;
    wait_until(c + 13);

    // Reset during WAIT_DONE aborts the word; priority restarts at index 0.
    busy_len = 20;
    c = cyc;
    bus.req = 4'b0100;
    expect_ev(EV_GRANT, 4'b0100, 8'hA5, c + 1);
    wait_until(c + 1);
    bus.req = 4'b0000;
    wait_until(c + 5);
    reset = 1'b0;
    @(negedge clk);
    check_zero_outputs("abort");
    @(negedge clk);
    reset = 1'b1;
    wait_until(c + 23);
    busy_len = 2;
    t = cyc;
    bus.req = 4'b1001;
    expect_ev(EV_GRANT, 4'b0001, 8'h11, t + 1);
    expect_ev(EV_DONE,  4'b0001, 8'h00, t + 5);
    expect_ev(EV_GRANT, 4'b1000, 8'h44, t + 7);
    expect_ev(EV_DONE,  4'b1000, 8'h00, t + 11);
    wait_until(t + 1);
    bus.req = 4'b1000;
    wait_until(t + 7);
    bus.req = 4'b0000;
    wait_until(t + 14);

    check("events_outstanding", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
